// File: rtl/hazard_unit_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline around it.
interface hazard_unit_if;
  logic [5:0]  op_code_id;
  logic [5:0]  formato_id;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic        branch_resolved;
  logic        stall_mux;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        br_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output op_code_id, formato_id, rs_id, rt_id,
    output id_ex_mem_read, id_ex_rt, branch_resolved,
    input  stall_mux, pc_write, if_id_write, if_id_flush,
    input  br_timeout, stall_cycles
  );

  modport slave (
    input  op_code_id, formato_id, rs_id, rt_id,
    input  id_ex_mem_read, id_ex_rt, branch_resolved,
    output stall_mux, pc_write, if_id_write, if_id_flush,
    output br_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: load-use bubble insertion and branch wait sequencing.
// Optional bubble counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned BR_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_unit_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [7:0] WAIT_LAST = 8'(BR_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    BR_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       br_timeout_q, br_timeout_d;

  logic is_branch;
  logic uses_rt;
  logic load_use;

  logic stall_mux;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;

  always_comb begin
    is_branch = (bus.op_code_id == OP_BEQ) || (bus.op_code_id == OP_BNE) ||
                (bus.op_code_id == OP_J) ||
                ((bus.op_code_id == OP_RTYPE) &&
                 ((bus.formato_id == FN_JR) || (bus.formato_id == FN_JALR)));
    uses_rt   = ((bus.op_code_id == OP_RTYPE) && (bus.formato_id != '0)) ||
                (bus.op_code_id == OP_BEQ) || (bus.op_code_id == OP_BNE) ||
                (bus.op_code_id == OP_SB)  || (bus.op_code_id == OP_SH)  ||
                (bus.op_code_id == OP_SW);
    load_use  = bus.id_ex_mem_read && (bus.id_ex_rt != '0) &&
                ((bus.id_ex_rt == bus.rs_id) || (uses_rt && (bus.id_ex_rt == bus.rt_id)));
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    br_timeout_d = br_timeout_q;
    stall_mux    = 1'b1;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        // Load-use wins over a branch; the branch stays in ID and is seen again.
        if (load_use) begin
          stall_mux   = 1'b0;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end else if (is_branch) begin
          state_d    = BR_WAIT;
          wait_cnt_d = '0;
        end
      end
      BR_WAIT: begin
        stall_mux   = 1'b0;
        if_id_flush = 1'b1;
        pc_write    = bus.branch_resolved;
        if (bus.branch_resolved) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          br_timeout_d = 1'b1;
          state_d      = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
    // Enables must read as pass-through while reset is held, whatever the inputs.
    if (!reset_n) begin
      stall_mux   = 1'b1;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      br_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      br_timeout_q <= br_timeout_d;
    end
  end

  assign bus.stall_mux   = stall_mux;
  assign bus.pc_write    = pc_write;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.br_timeout  = br_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!stall_mux && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller in the ID stage. It generates the `stall_mux` enable consumed by the ID-stage control decoder: 1 passes decoded control, 0 injects a bubble. It also drives the PC and IF/ID register enables and the IF/ID flush. It detects load-use hazards combinationally and sequences a branch/jump wait state until EX signals resolution.

## Interface
- `BR_TIMEOUT`, default 8: maximum BR_WAIT cycles before forced exit (legal 2..255).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op_code_id` in 6: opcode of the instruction in IF/ID.
- `formato_id` in 6: funct field of the instruction in IF/ID.
- `rs_id` in 5: rs of the IF/ID instruction.
- `rt_id` in 5: rt of the IF/ID instruction.
- `id_ex_mem_read` in 1: MemRead of the instruction in ID/EX.
- `id_ex_rt` in 5: destination rt of the instruction in ID/EX.
- `branch_resolved` in 1: one-cycle pulse from EX when a branch/jump target is final.
- `stall_mux` out 1: 1 = pass control, 0 = bubble.
- `pc_write` out 1: PC load enable.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: IF/ID loads NOP.
- `br_timeout` out 1: sticky flag, set on watchdog expiry.
- `stall_cycles` out 16: saturating bubble counter (see Configuration).

## Operation
- Decode:
  - `is_branch` = opcode 000100 (BEQ), 000101 (BNE), or 000010 (J); or opcode 000000 with funct 001000 (JR) or 001001 (JALR).
  - `uses_rt` = opcode 000000 with funct ≠ 000000, or BEQ, BNE, SB (101000), SH (101001), SW (101011).
- `load_use` = `id_ex_mem_read` & (`id_ex_rt` ≠ 0) & ((`id_ex_rt` == `rs_id`) | (`uses_rt` & `id_ex_rt` == `rt_id`)).
- FSM, 2 states, registered: RUN and BR_WAIT. Reset state is RUN.
- RUN with `load_use`:
  - Outputs: `stall_mux`=0, `pc_write`=0, `if_id_write`=0, `if_id_flush`=0.
  - Stay in RUN. The hazard clears next cycle because the bubble sits in ID/EX.
- RUN with `is_branch` and no `load_use`:
  - Outputs: `stall_mux`=1, `pc_write`=1, `if_id_write`=1, `if_id_flush`=0.
  - Next state BR_WAIT; wait counter cleared to 0.
- RUN otherwise: all enables 1, flush 0.
- BR_WAIT:
  - Outputs: `stall_mux`=0, `if_id_write`=1, `if_id_flush`=1, `pc_write`=`branch_resolved`.
  - On `branch_resolved`: go to RUN.
  - Else on counter == `BR_TIMEOUT`-1: set `br_timeout`, go to RUN.
  - Else: counter increments.
- Priority: `load_use` beats `is_branch`. The branch is held in ID and re-evaluated next cycle.
- `branch_resolved` in RUN is ignored.
- `br_timeout` clears only on reset.
- Wait counter is 8 bits wide.

## Timing
- Reset values: state RUN, counter 0, `br_timeout` 0, `stall_cycles` 0.
- Output values during reset: `stall_mux`=1, `pc_write`=1, `if_id_write`=1, `if_id_flush`=0.
- Outputs are combinational from state and inputs, with zero latency. State and counters update on the rising `clk` edge.
- Load-use costs exactly 1 bubble cycle.
- Branch penalty = N+1 cycles, where N is the number of cycles from BR_WAIT entry to the `branch_resolved` pulse inclusive:
  - N wait cycles with flush active;
  - plus the return-to-RUN fetch of the target.
- Resolve pulse on the first BR_WAIT cycle: 1 wait cycle, PC loads the target in that same cycle.
- Timeout exit: exactly `BR_TIMEOUT` BR_WAIT cycles. `br_timeout` is visible from the cycle after the last wait cycle.
- Asynchronous reset assertion mid-BR_WAIT forces RUN and all reset values immediately.
- Release of `reset_n` takes effect at the next rising edge.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments every clock where `stall_mux`==0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: counter logic is removed and `stall_cycles` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Load-use:
  - LW in ID/EX (`id_ex_mem_read`=1, `id_ex_rt`=5); IF/ID holds ADD with rs=5 -> one cycle of `stall_mux`=0, `pc_write`=0, `if_id_write`=0; next cycle (`id_ex_mem_read`=0) all enables 1.
  - Repeat with `id_ex_rt`=0 or with ADDI rt=5 in ID -> no stall.
- BEQ in ID (op 000100) with no hazard -> stall_mux=1 that cycle; then BR_WAIT with `if_id_flush`=1 and `pc_write`=0; `branch_resolved` on the 2nd wait cycle -> `pc_write`=1 that cycle, RUN next cycle, 2 flushed cycles total.
- JR (op 0, funct 001000) in ID with `id_ex_mem_read`=1 and `id_ex_rt`==`rs_id` -> load stall first; BR_WAIT is entered the following cycle, not in the same cycle.
- `BR_TIMEOUT`=4, J in ID, no `branch_resolved` -> 4 wait cycles, then RUN with `br_timeout`=1; `br_timeout` stays 1 until `reset_n`=0.
- `reset_n` pulled low in the 2nd BR_WAIT cycle -> outputs immediately at reset values; after release, a `branch_resolved` pulse produces no `pc_write` change.
- With `HAZARD_PERF_CNT_EN`: 3 load stalls plus a 2-cycle branch wait -> `stall_cycles`=5. Preload 16'hFFFE and give 3 more stall cycles -> value stays 16'hFFFF. Without the macro -> always 0.
